// File: rtl/upload_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : upload_writer_pkg
//  Purpose  : Shared types for the ioctl-to-memory-bus upload writer.
//  Revision : 1.0 - initial release
// ============================================================================
package upload_writer_pkg;

    localparam int c_ADDR_W = 27;
    localparam int c_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        BRAM_WR,
        SD_READY,
        SD_WR,
        FINISH
    } upload_state_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } upload_entry_t;

endpackage
`default_nettype wire

// File: rtl/upload_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : memory_bus_if
//  Purpose  : Byte-wide memory router port. The device side drives the
//             request, the router side answers with the SDRAM handshake.
//  Revision : 1.0 - initial release
// ============================================================================
interface memory_bus_if;
    import upload_writer_pkg::*;

    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] data;
    logic                rnw;
    logic                ram_cs;
    logic                sram_cs;
    logic                sdram_ready;
    logic                sdram_done;

    modport device_mp (
        output addr, data, rnw, ram_cs, sram_cs,
        input  sdram_ready, sdram_done
    );

    modport router_mp (
        input  addr, data, rnw, ram_cs, sram_cs,
        output sdram_ready, sdram_done
    );
endinterface
`default_nettype wire

// File: rtl/upload_writer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : upload_fifo
//  Purpose  : Small synchronous FIFO of address/data entries. A clear wipes
//             the contents but still accepts a push in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module upload_fifo
    import upload_writer_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH),
    localparam int c_CNT_W    = c_PTR_W + 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               clear,
    input  wire logic               push,
    input  wire upload_entry_t      push_entry,
    output logic                    push_ok,
    input  wire logic               pop,
    output upload_entry_t           pop_entry,
    output logic [c_CNT_W-1:0]      count,
    output logic                    full,
    output logic                    empty
);

    upload_entry_t        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_pop;
    logic [c_PTR_W-1:0]   w_wr_slot;

    assign full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign w_do_pop  = pop && !empty && !clear;
    assign push_ok   = push && (clear || !full || w_do_pop);
    assign w_wr_slot = clear ? '0 : r_wr_ptr;
    assign pop_entry = r_mem[r_rd_ptr];

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            r_mem[w_wr_slot] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= push_ok ? c_PTR_W'(1) : '0;
            r_count  <= push_ok ? c_CNT_W'(1) : '0;
        end else begin
            if (push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(push_ok) - c_CNT_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/upload_writer.sv
`default_nettype none
// ============================================================================
//  Module   : upload_writer
//  Purpose  : Buffers the HPS ioctl download stream and writes it byte by
//             byte onto the memory router upload port (BRAM single-cycle,
//             SDRAM handshaked with a per-write timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module upload_writer
    import upload_writer_pkg::*;
#(
    parameter int BRAM_WIDTH = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                ioctl_download,
    input  wire logic                ioctl_wr,
    input  wire logic [c_ADDR_W-1:0] ioctl_addr,
    input  wire logic [c_DATA_W-1:0] ioctl_dout,
    output logic                     ioctl_wait,
    input  wire logic [c_ADDR_W-1:0] base_addr,
    memory_bus_if.device_mp          memory_bus_upload,
    output logic                     upload,
    output logic [c_ADDR_W-1:0]      bytes_written,
    output logic                     error
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int c_TO_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    upload_state_t          r_state;
    upload_state_t          w_state_next;
    logic [c_ADDR_W-1:0]    r_base;
    logic [c_ADDR_W-1:0]    r_addr;
    logic [c_DATA_W-1:0]    r_data;
    logic [c_ADDR_W-1:0]    r_bytes;
    logic                   r_error;
    logic                   r_wait;
    logic [c_TO_W-1:0]      r_to_cnt;

    logic                   w_push;
    logic                   w_push_ok;
    logic                   w_pop;
    logic                   w_clear;
    logic                   w_full;
    logic                   w_empty;
    logic [c_CNT_W-1:0]     w_count;
    logic [c_CNT_W-1:0]     w_count_next;
    logic [c_ADDR_W-1:0]    w_base;
    upload_entry_t          w_push_entry;
    upload_entry_t          w_pop_entry;
    logic                   w_is_bram;
    logic                   w_bus_active;
    logic                   w_sd_ok;
    logic                   w_sd_fail;

    // Before SETUP has latched the base, bytes use the live base address.
    assign w_base            = (r_state == IDLE || r_state == SETUP) ? base_addr : r_base;
    assign w_push            = ioctl_download && ioctl_wr;
    assign w_push_entry.addr = w_base + ioctl_addr;
    assign w_push_entry.data = ioctl_dout;
    assign w_clear           = (r_state == SETUP);
    assign w_pop             = (r_state == FETCH) && !w_empty;
    assign w_is_bram         = (w_pop_entry.addr[c_ADDR_W-1:BRAM_WIDTH] == '0);
    assign w_sd_ok           = (r_state == SD_WR) && memory_bus_upload.sdram_done;
    // Counter starts at 0 on SD_WR entry, so ram_cs stays up TIMEOUT cycles.
    assign w_sd_fail         = (r_state == SD_WR) && !memory_bus_upload.sdram_done &&
                               (r_to_cnt == c_TO_W'(TIMEOUT - 1));
    assign w_count_next      = w_clear ? c_CNT_W'(w_push_ok)
                                       : w_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop);

    upload_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .push       (w_push),
        .push_entry (w_push_entry),
        .push_ok    (w_push_ok),
        .pop        (w_pop),
        .pop_entry  (w_pop_entry),
        .count      (w_count),
        .full       (w_full),
        .empty      (w_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a new download level is only looked at from IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (ioctl_download) w_state_next = SETUP;
            SETUP:    w_state_next = FETCH;
            FETCH: begin
                if (!w_empty) begin
                    w_state_next = w_is_bram ? BRAM_WR : SD_READY;
                end else if (!ioctl_download) begin
                    w_state_next = FINISH;
                end
            end
            BRAM_WR:  w_state_next = FETCH;
            SD_READY: if (memory_bus_upload.sdram_ready) w_state_next = SD_WR;
            SD_WR:    if (w_sd_ok || w_sd_fail) w_state_next = FETCH;
            FINISH:   w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Transfer datapath: latched base, current write, counters and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base   <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_bytes  <= '0;
            r_error  <= 1'b0;
            r_wait   <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_wait   <= (w_count_next >= c_CNT_W'(FIFO_DEPTH - 1));
            r_to_cnt <= (r_state == SD_WR) ? r_to_cnt + c_TO_W'(1) : '0;
            if (w_clear) begin
                r_base  <= base_addr;
                r_bytes <= '0;
                r_error <= 1'b0;
            end else begin
                if ((r_state == BRAM_WR) || w_sd_ok) begin
                    r_bytes <= r_bytes + c_ADDR_W'(1);
                end
                if ((w_push && !w_push_ok) || w_sd_fail) begin
                    r_error <= 1'b1;
                end
            end
            if (w_pop) begin
                r_addr <= w_pop_entry.addr;
                r_data <= w_pop_entry.data;
            end
        end
    end

    // Bus outputs decode straight from the state so reset idles them at once.
    assign w_bus_active             = (r_state == BRAM_WR) || (r_state == SD_WR);
    assign memory_bus_upload.ram_cs  = w_bus_active;
    assign memory_bus_upload.rnw     = !w_bus_active;
    assign memory_bus_upload.sram_cs = 1'b0;
    assign memory_bus_upload.addr    = w_bus_active ? r_addr : '0;
    assign memory_bus_upload.data    = w_bus_active ? r_data : '0;

    assign upload        = (r_state != IDLE);
    assign ioctl_wait    = r_wait;
    assign bytes_written = r_bytes;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_upload_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_upload_writer
//  Purpose  : Directed self-checking bench for upload_writer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_upload_writer;

    localparam int BW = 18;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [26:0] base_addr = '0;
    logic        ioctl_wait;
    logic        upload;
    logic [26:0] bytes_written;
    logic        error;

    memory_bus_if bus ();

    upload_writer dut (
        .clk               (clk),
        .reset             (reset),
        .ioctl_download    (ioctl_download),
        .ioctl_wr          (ioctl_wr),
        .ioctl_addr        (ioctl_addr),
        .ioctl_dout        (ioctl_dout),
        .ioctl_wait        (ioctl_wait),
        .base_addr         (base_addr),
        .memory_bus_upload (bus),
        .upload            (upload),
        .bytes_written     (bytes_written),
        .error             (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_wr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM responder: done pulses done_dly cycles after ram_cs rises.
    int done_dly = 3;
    bit never_done = 1'b0;
    int cs_cnt = 0;
    initial begin
        bus.sdram_ready = 1'b1;
        bus.sdram_done  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ram_cs === 1'b1) cs_cnt++;
            else cs_cnt = 0;
            bus.sdram_done = (bus.ram_cs === 1'b1) && !never_done && (cs_cnt == done_dly + 1);
        end
    end

    // Bus monitor: logs completed writes, pulse lengths and rise cycles.
    logic [34:0] wr_q[$];
    int          len_q[$];
    int          rise_q[$];
    int          proto_err = 0;
    int          run = 0;
    logic        prev_cs = 1'b0;
    logic [26:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    always @(negedge clk) begin
        if (bus.sram_cs !== 1'b0) proto_err++;
        if (bus.ram_cs === 1'b1) begin
            if (bus.rnw !== 1'b0) proto_err++;
            if (!prev_cs) begin
                rise_q.push_back(cyc);
                run = 0;
            end else if (bus.addr !== prev_addr || bus.data !== prev_data) begin
                proto_err++;
            end
            run++;
            if (bus.addr[26:BW] == '0 || bus.sdram_done === 1'b1)
                wr_q.push_back({bus.addr, bus.data});
        end else begin
            if (bus.rnw !== 1'b1 || bus.addr !== '0 || bus.data !== '0) proto_err++;
            if (prev_cs) len_q.push_back(run);
        end
        prev_cs   = (bus.ram_cs === 1'b1);
        prev_addr = bus.addr;
        prev_data = bus.data;
    end

    function automatic logic [34:0] wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 'x;
    endfunction
    function automatic int len_at(input int i);
        return (i < len_q.size()) ? len_q[i] : -1;
    endfunction
    function automatic int rise_at(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wr_q.delete();
        len_q.delete();
        rise_q.delete();
        proto_err = 0;
    endtask

    task automatic send(input logic [26:0] off, input logic [7:0] d);
        ioctl_addr  = off;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        last_wr_cyc = cyc;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic start_xfer(input logic [26:0] b);
        base_addr      = b;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_xfer(output int fall_cyc);
        ioctl_download = 1'b0;
        fall_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (upload === 1'b0) begin
                fall_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_len(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (len_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++; if (upload !== 1'b0) begin bad++; $display("FAIL reset_upload got=%b want=0", upload); end
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b want=0", ioctl_wait); end
        total++; if (bytes_written !== 27'd0) begin bad++; $display("FAIL reset_bytes got=%0d want=0", bytes_written); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        total++; if ({bus.ram_cs, bus.rnw, bus.sram_cs, bus.addr, bus.data} !== {3'b010, 35'd0})
            begin bad++; $display("FAIL reset_bus got cs=%b rnw=%b addr=%h want idle", bus.ram_cs, bus.rnw, bus.addr); end
    endtask

    task automatic test_bram;
        int c0, fall;
        clear_logs();
        base_addr = 27'h0;
        ioctl_download = 1'b1;
        total++; if (upload !== 1'b0) begin bad++; $display("FAIL bram_upload_early got=%b want=0", upload); end
        tick();
        total++; if (upload !== 1'b1) begin bad++; $display("FAIL bram_upload_rise got=%b want=1", upload); end
        tick();
        send(27'h0, 8'hA5);
        c0 = last_wr_cyc;
        send(27'h1, 8'h5A);
        end_xfer(fall);
        total++; if (wr_q.size() != 2) begin bad++; $display("FAIL bram_count got=%0d want=2", wr_q.size()); end
        total++; if (wr_at(0) !== {27'h0, 8'hA5}) begin bad++; $display("FAIL bram_w0 got=%h want=%h", wr_at(0), {27'h0, 8'hA5}); end
        total++; if (wr_at(1) !== {27'h1, 8'h5A}) begin bad++; $display("FAIL bram_w1 got=%h want=%h", wr_at(1), {27'h1, 8'h5A}); end
        total++; if (len_at(0) != 1 || len_at(1) != 1) begin bad++; $display("FAIL bram_pulse got=%0d,%0d want=1,1", len_at(0), len_at(1)); end
        total++; if (rise_at(0) != c0 + 2) begin bad++; $display("FAIL bram_latency got=%0d want=%0d", rise_at(0), c0 + 2); end
        total++; if (rise_at(1) != c0 + 4) begin bad++; $display("FAIL bram_rate got=%0d want=%0d", rise_at(1), c0 + 4); end
        total++; if (fall != c0 + 7) begin bad++; $display("FAIL bram_upload_fall got=%0d want=%0d", fall, c0 + 7); end
        total++; if (bytes_written !== 27'd2) begin bad++; $display("FAIL bram_bytes got=%0d want=2", bytes_written); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL bram_error got=%b want=0", error); end
        total++; if (proto_err != 0) begin bad++; $display("FAIL bram_protocol got=%0d want=0", proto_err); end
    endtask

    task automatic test_sdram;
        int r, fall;
        clear_logs();
        done_dly = 3;
        never_done = 1'b0;
        bus.sdram_ready = 1'b0;
        start_xfer(27'h40000);
        send(27'h0, 8'h3C);
        repeat (5) tick();
        r = cyc;
        bus.sdram_ready = 1'b1;
        end_xfer(fall);
        total++; if (rise_at(0) != r + 1) begin bad++; $display("FAIL sd_rise got=%0d want=%0d", rise_at(0), r + 1); end
        total++; if (len_at(0) != 4) begin bad++; $display("FAIL sd_pulse got=%0d want=4", len_at(0)); end
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL sd_count got=%0d want=1", wr_q.size()); end
        total++; if (wr_at(0) !== {27'h40000, 8'h3C}) begin bad++; $display("FAIL sd_w0 got=%h want=%h", wr_at(0), {27'h40000, 8'h3C}); end
        total++; if (bytes_written !== 27'd1) begin bad++; $display("FAIL sd_bytes got=%0d want=1", bytes_written); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL sd_error got=%b want=0", error); end
        total++; if (proto_err != 0) begin bad++; $display("FAIL sd_protocol got=%0d want=0", proto_err); end
    endtask

    task automatic test_back_pressure;
        int fall, first_wait, k;
        clear_logs();
        done_dly = 10;
        first_wait = -1;
        start_xfer(27'h40000);
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (ioctl_wait === 1'b1 && k < 3000) begin
                if (first_wait < 0) first_wait = i;
                tick();
                k++;
            end
            send(27'(i), 8'h10 + 8'(i));
        end
        end_xfer(fall);
        total++; if (first_wait != 4) begin bad++; $display("FAIL bp_wait_point got=%0d want=4", first_wait); end
        total++; if (wr_q.size() != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", wr_q.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_at(i) !== {27'h40000 + 27'(i), 8'h10 + 8'(i)}) begin
                bad++; $display("FAIL bp_w%0d got=%h want=%h", i, wr_at(i), {27'h40000 + 27'(i), 8'h10 + 8'(i)});
            end
        end
        total++; if (bytes_written !== 27'd8) begin bad++; $display("FAIL bp_bytes got=%0d want=8", bytes_written); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL bp_error got=%b want=0", error); end
    endtask

    task automatic test_overflow;
        int fall;
        clear_logs();
        done_dly = 10;
        start_xfer(27'h40000);
        for (int i = 0; i < 8; i++) send(27'(i), 8'h20 + 8'(i));
        end_xfer(fall);
        total++; if (bytes_written !== 27'd5) begin bad++; $display("FAIL ovf_bytes got=%0d want=5", bytes_written); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%b want=1", error); end
        total++; if (wr_q.size() != 5) begin bad++; $display("FAIL ovf_count got=%0d want=5", wr_q.size()); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (wr_at(i) !== {27'h40000 + 27'(i), 8'h20 + 8'(i)}) begin
                bad++; $display("FAIL ovf_w%0d got=%h want=%h", i, wr_at(i), {27'h40000 + 27'(i), 8'h20 + 8'(i)});
            end
        end
        base_addr = 27'h0;
        ioctl_download = 1'b1;
        tick();
        total++; if (error !== 1'b1) begin bad++; $display("FAIL ovf_error_held got=%b want=1", error); end
        tick();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ovf_error_clear got=%b want=0", error); end
        total++; if (bytes_written !== 27'd0) begin bad++; $display("FAIL ovf_bytes_clear got=%0d want=0", bytes_written); end
        end_xfer(fall);
    endtask

    task automatic test_timeout;
        int fall;
        bit ok;
        clear_logs();
        never_done = 1'b1;
        done_dly = 2;
        start_xfer(27'h40000);
        send(27'h0, 8'h77);
        send(27'h1, 8'h88);
        wait_len(1, ok);
        never_done = 1'b0;
        end_xfer(fall);
        total++; if (!ok) begin bad++; $display("FAIL to_wait got=expired want=pulse_end"); end
        total++; if (len_at(0) != 255) begin bad++; $display("FAIL to_pulse got=%0d want=255", len_at(0)); end
        total++; if (len_at(1) != 3) begin bad++; $display("FAIL to_next_pulse got=%0d want=3", len_at(1)); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL to_error got=%b want=1", error); end
        total++; if (bytes_written !== 27'd1) begin bad++; $display("FAIL to_bytes got=%0d want=1", bytes_written); end
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL to_count got=%0d want=1", wr_q.size()); end
        total++; if (wr_at(0) !== {27'h40001, 8'h88}) begin bad++; $display("FAIL to_w0 got=%h want=%h", wr_at(0), {27'h40001, 8'h88}); end
    endtask

    task automatic test_reset_mid;
        int fall;
        clear_logs();
        never_done = 1'b1;
        start_xfer(27'h40000);
        for (int i = 0; i < 4; i++) send(27'(i), 8'h30 + 8'(i));
        total++; if (bus.ram_cs !== 1'b1) begin bad++; $display("FAIL rst_pre_cs got=%b want=1", bus.ram_cs); end
        total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL rst_pre_wait got=%b want=1", ioctl_wait); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.ram_cs !== 1'b0) begin bad++; $display("FAIL rst_cs got=%b want=0", bus.ram_cs); end
        total++; if (upload !== 1'b0) begin bad++; $display("FAIL rst_upload got=%b want=0", upload); end
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b want=0", ioctl_wait); end
        ioctl_download = 1'b0;
        never_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_logs();
        start_xfer(27'h0);
        total++; if (bytes_written !== 27'd0) begin bad++; $display("FAIL rst_new_bytes got=%0d want=0", bytes_written); end
        send(27'h5, 8'h99);
        end_xfer(fall);
        total++; if (bytes_written !== 27'd1) begin bad++; $display("FAIL rst_after_bytes got=%0d want=1", bytes_written); end
        total++; if (wr_at(0) !== {27'h5, 8'h99}) begin bad++; $display("FAIL rst_after_w0 got=%h want=%h", wr_at(0), {27'h5, 8'h99}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bram();
        test_sdram();
        test_back_pressure();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/upload_writer.md
# upload_writer

Drives the upload port of the system memory router from the HPS ioctl download stream. Buffers incoming bytes in a small FIFO, throttles the HPS with `ioctl_wait`, and issues one write per byte on the memory bus. Single-cycle writes go to the BRAM region; SDRAM-region writes are handshaked on `sdram_ready`/`sdram_done`. Asserts `upload` so the router selects this port for the whole transfer, including the drain after the HPS finishes.

## Interface
- `BRAM_WIDTH`, 18: address bits covered by BRAM. Addresses with bits [26:BRAM_WIDTH] == 0 are BRAM.
- `FIFO_DEPTH`, 4: FIFO entries. Power of two, ≥ 2.
- `TIMEOUT`, 255: maximum cycles to wait for `sdram_done` per SDRAM write.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `ioctl_download` in 1: HPS transfer active (level).
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 27: byte offset within the image.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: HPS must stall.
- `base_addr` in 27: image base. Latched at transfer start.
- `memory_bus_upload` memory_bus_if.device_mp: drives `addr`, `data`, `rnw`, `ram_cs`, `sram_cs`; samples `sdram_ready`, `sdram_done`.
- `upload` out 1: router select.
- `bytes_written` out 27: completed writes in the current or last transfer.
- `error` out 1: sticky fault flag. Cleared at the next transfer start.

## Operation
- **FIFO**
  - Each entry is {addr = base_addr_latched + ioctl_addr (mod 2^27), data}.
  - A push occurs on `ioctl_wr` while `ioctl_download` is high. `ioctl_wr` while `ioctl_download` is low is ignored.
  - Push and pop in the same cycle is legal; the count is unchanged.
  - Push while full: the byte is dropped and `error` is set.
- **`ioctl_wait`** is registered and equals (count ≥ FIFO_DEPTH−1) after the current cycle's push/pop.
- **FSM states**
  - IDLE: `upload`=0, bus idle. If `ioctl_download`=1, go to SETUP.
  - SETUP (1 cycle): latch `base_addr`; clear `bytes_written`, `error`, FIFO; `upload`=1; go to FETCH.
  - FETCH
    - FIFO not empty: pop into the address/data registers. BRAM region goes to BRAM_WR; otherwise go to SD_READY.
    - FIFO empty and `ioctl_download`=0: go to FINISH.
    - Otherwise stay in FETCH.
  - BRAM_WR (1 cycle): `ram_cs`=1, `rnw`=0; `bytes_written`++; go to FETCH.
  - SD_READY: bus idle. When `sdram_ready`=1, go to SD_WR.
  - SD_WR
    - `ram_cs`=1, `rnw`=0, address and data held stable.
    - On `sdram_done`=1: drop `ram_cs` next cycle, `bytes_written`++, go to FETCH.
    - After TIMEOUT cycles without done: set `error`, drop the byte, go to FETCH.
  - FINISH (1 cycle): `upload`=1, bus idle; go to IDLE. `upload` falls on entry to IDLE.
- **Bus idle values:** `ram_cs`=0, `rnw`=1, `sram_cs`=0, `addr`=0, `data`=0. `sram_cs` is always 0. `q` is never sampled.
- **Bus address** is the full 27-bit address; the router applies region offsets.
- **`ioctl_download` rising again** before FINISH: the current transfer continues and no restart occurs. IDLE then starts a new transfer if the level is still high.

## Timing
- **Reset values:** IDLE; `upload`=0; `ioctl_wait`=0; `bytes_written`=0; `error`=0; FIFO empty; bus idle.
- **Reset mid-transfer:** immediate abort. All registers take reset values, including `ram_cs`=0 during SD_WR.
- **`upload` asserts** 1 cycle after `ioctl_download` is first seen high in IDLE.
- **BRAM byte:**
  - Push at cycle n.
  - FETCH pops at n+1 at the earliest.
  - `ram_cs` high at n+2 for exactly 1 cycle.
  - Sustained throughput: 1 byte per 2 cycles.
- **SDRAM byte:** the bus shows `ram_cs` from SD_WR entry through the cycle `sdram_done` is sampled.
- **Counters:** `bytes_written` is a 27-bit counter and wraps. The timeout counter is 8 bits minimum, sized as clog2(TIMEOUT+1).

## Structure
- Package `upload_writer_pkg` holds:
  - `upload_state_t` enum (IDLE, SETUP, FETCH, BRAM_WR, SD_READY, SD_WR, FINISH).
  - `upload_entry_t` struct {logic [26:0] addr; logic [7:0] data}.
- Sub-module `upload_fifo`: synchronous FIFO of `upload_entry_t`, parameter FIFO_DEPTH, with push/pop/count/full/empty outputs and async reset.

## Test plan
- **BRAM write:** `base_addr`=0; bytes 0xA5, 0x5A at offsets 0, 1 → two single-cycle `ram_cs` pulses at addr 0x0 and 0x1 with matching data. `bytes_written`=2. `upload` falls 1 cycle after FINISH.
- **SDRAM write:** `base_addr`=0x40000, `sdram_ready` low for 5 cycles, `sdram_done` 3 cycles after `ram_cs` → `ram_cs` held 4 cycles at addr 0x40000. `error`=0.
- **Back-pressure:** FIFO_DEPTH=4, burst of 8 consecutive `ioctl_wr`, HPS obeying `ioctl_wait`, `sdram_done` delayed 10 cycles → `ioctl_wait` rises at count 3. All 8 bytes written in order; no `error`.
- **Overflow:** same burst with the HPS ignoring `ioctl_wait` → extra bytes dropped, `error`=1. `error` clears at the next SETUP.
- **Timeout:** `sdram_done` never asserted → `ram_cs` drops after 255 cycles, `error`=1, the next byte proceeds, `bytes_written` excludes the failed byte.
- **Reset:** assert `reset` during SD_WR → `ram_cs`, `upload`, `ioctl_wait` go to 0 asynchronously. A new download after release starts with `bytes_written`=0.
